// File: rtl/tm_arb_pkg.sv
// Shared types and timing helpers for the TM1638 display arbiter.
package tm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BLANK = 2'd2
  } arb_state_t;

  // Minimum ownership time in clock cycles.
  function automatic int slice_cycles(int clk_mhz, int slice_ms);
    return clk_mhz * 1000 * slice_ms;
  endfunction

  // Blanking interval between owners in clock cycles.
  function automatic int blank_cycles(int clk_mhz, int blank_us);
    return clk_mhz * blank_us;
  endfunction

  // Bits needed for one counter that can hold either interval.
  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tm_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping.
module tm_rr_pick #(
  parameter int n = 4
) (
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(n)-1:0] index
);

  localparam int W = $clog2(n);

  int cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = n - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if (req[cand]) begin
        valid = 1'b1;
        index = W'(cand);
      end
    end
  end

endmodule

// File: rtl/tm_display_arbiter.sv
// Shares one TM1638 board between n_req requesters: round-robin grant,
// time-slice preemption, blanking between owners, key routing to owner.
// Optional: TM_ARB_OWNER_LEDS_EN shows the owner one-hot on ledr[n_req-1:0].
module tm_display_arbiter
  import tm_arb_pkg::*;
#(
  parameter int clk_mhz  = 27,
  parameter int n_req    = 4,
  parameter int w_digit  = 8,
  parameter int w_led    = 8,
  parameter int w_key    = 8,
  parameter int slice_ms = 500,
  parameter int blank_us = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [n_req-1:0]           req,
  output logic [n_req-1:0]           gnt,
  output logic [$clog2(n_req)-1:0]   owner,
  input  logic [n_req*8-1:0]         req_hgfedcba,
  input  logic [n_req*w_digit-1:0]   req_digit,
  input  logic [n_req*w_led-1:0]     req_led,
  output logic [7:0]                 hgfedcba,
  output logic [w_digit-1:0]         digit,
  output logic [w_led-1:0]           ledr,
  input  logic [w_key-1:0]           keys,
  output logic [n_req*w_key-1:0]     req_keys
);

  localparam int SLICE_LEN = slice_cycles(clk_mhz, slice_ms);
  localparam int BLANK_LEN = blank_cycles(clk_mhz, blank_us);
  localparam int CW        = cnt_width(SLICE_LEN, BLANK_LEN);
  localparam int OW        = $clog2(n_req);

  localparam logic [CW-1:0] SLICE_MAX  = CW'(SLICE_LEN);
  localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE_LEN - 1);
  localparam logic [CW-1:0] BLANK_MAX  = CW'(BLANK_LEN);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LEN - 1);

  arb_state_t             state, nxt_state;
  logic [OW-1:0]          ptr, next_ptr, pick_ptr, pick_idx, nxt_owner;
  logic                   pick_valid, slice_done, others_req, key_mask;
  logic [CW-1:0]          cnt, cnt_cap;
  logic [n_req-1:0]       nxt_onehot;
  logic [7:0]             seg_sel;
  logic [w_digit-1:0]     dig_sel;
  logic [w_led-1:0]       led_sel;
  logic [n_req*w_key-1:0] keys_route;

  // After blanking the search starts just past the previous owner, which
  // therefore wins only when it is the sole requester.
  assign next_ptr   = (owner == OW'(n_req - 1)) ? '0 : owner + 1'b1;
  assign pick_ptr   = (state == BLANK) ? next_ptr : ptr;
  assign slice_done = (cnt >= SLICE_LAST);
  assign others_req = |(req & ~gnt);
  assign cnt_cap    = (state == GRANT) ? SLICE_MAX : BLANK_MAX;

  tm_rr_pick #(.n(n_req)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Next-state and next-owner decision.
  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          nxt_state = GRANT;
          nxt_owner = pick_idx;
        end
      end
      GRANT: begin
        if (!req[owner] || (slice_done && others_req)) nxt_state = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          if (pick_valid) begin
            nxt_state = GRANT;
            nxt_owner = pick_idx;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Output mux keyed on the next owner so gnt and data switch together.
  always_comb begin
    nxt_onehot = n_req'(1) << nxt_owner;
    seg_sel    = req_hgfedcba[int'(nxt_owner)*8 +: 8];
    dig_sel    = req_digit[int'(nxt_owner)*w_digit +: w_digit];
    led_sel    = req_led[int'(nxt_owner)*w_led +: w_led];
`ifdef TM_ARB_OWNER_LEDS_EN
    led_sel[n_req-1:0] = nxt_onehot;
`endif
    keys_route = '0;
    if (state == GRANT && nxt_state == GRANT && !key_mask)
      keys_route[int'(nxt_owner)*w_key +: w_key] = keys;
  end

  // State, owner, pointer and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      if (state == BLANK && nxt_state != BLANK) ptr <= next_ptr;
      gnt <= (nxt_state == GRANT) ? nxt_onehot : '0;
    end
  end

  // Shared slice/blank counter: cleared on every state change, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (state != nxt_state) cnt <= '0;
    else if (state != IDLE && cnt != cnt_cap) cnt <= cnt + 1'b1;
  end

  // Key mask: armed on each new grant, released once all keys are up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_mask <= 1'b1;
    else if (nxt_state == GRANT && state != GRANT) key_mask <= 1'b1;
    else if (state == GRANT && keys == '0) key_mask <= 1'b0;
  end

  // Registered board outputs; zero whenever nobody holds the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hgfedcba <= '0;
      digit    <= '0;
      ledr     <= '0;
      req_keys <= '0;
    end else if (nxt_state == GRANT) begin
      hgfedcba <= seg_sel;
      digit    <= dig_sel;
      ledr     <= led_sel;
      req_keys <= keys_route;
    end else begin
      hgfedcba <= '0;
      digit    <= '0;
      ledr     <= '0;
      req_keys <= '0;
    end
  end

endmodule

// File: doc/tm_display_arbiter.md
Name: tm_display_arbiter

Overview:
- Shares the single TM1638 board (8 digits, 8 LEDs, 8 keys) between several requesters, e.g. the pattern driver, a debug counter and a status monitor.
- Sits between the requesters and tm1638_board_controller.
- Grants ownership with round-robin priority and time-slice preemption, blanks the display between owners, and routes key state to the current owner only.

Parameters:
- clk_mhz, 27: clock frequency in MHz; used for time constants.
- n_req, 4: number of requesters (2..8).
- w_digit, 8: digit select width.
- w_led, 8: LED bar width.
- w_key, 8: key vector width.
- slice_ms, 500: minimum ownership time before preemption.
- blank_us, 100: blanking interval between owners.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req  in  n_req  level request per requester; held while the requester wants the display.
- gnt  out  n_req  one-hot grant; all zero when idle or blanking.
- owner  out  $clog2(n_req)  index of the current/last owner.
- req_hgfedcba  in  n_req*8  per-requester segment data; slice i = bits [8i+7:8i].
- req_digit  in  n_req*w_digit  per-requester digit select.
- req_led  in  n_req*w_led  per-requester LED pattern.
- hgfedcba  out  8  to board controller.
- digit  out  w_digit  to board controller.
- ledr  out  w_led  to board controller.
- keys  in  w_key  key state from board controller.
- req_keys  out  n_req*w_key  keys routed to owner only; other slices zero.

Behaviour:
- Constants: SLICE = clk_mhz*1000*slice_ms cycles; BLANK = clk_mhz*blank_us cycles. Counter width is sized for the larger of the two; the counter saturates.
- Reset (async, rst_n=0): state IDLE; gnt, hgfedcba, digit, ledr, req_keys = 0; owner = 0; rr pointer = 0; key mask armed.
- IDLE:
  - Display outputs are 0.
  - If any req bit is set, pick the first set bit searching from ptr upward with wrap. Go to GRANT with gnt, owner and counter=0 registered in that cycle.
- GRANT:
  - Display outputs are registered copies of the owner's slices (1-cycle latency from req_* inputs).
  - Counter increments, saturating at SLICE.
  - Owner's req drops → BLANK, immediately.
  - Counter == SLICE and any other req set → BLANK (preempt).
  - Counter == SLICE with no other request → stay in GRANT, no timeout.
- BLANK:
  - gnt = 0; display outputs = 0; req_keys = 0.
  - Counter counts to BLANK.
  - Then ptr = owner+1 (mod n_req). Pick the next requester from ptr → GRANT, or go to IDLE if none. The previous owner is eligible only if it is the sole requester.
- Simultaneous events: an owner req drop in the same cycle as slice expiry is a single transition to BLANK.
  - A req that rises during BLANK is considered at BLANK exit.
  - A req that drops during BLANK is not granted.
- Key routing:
  - On entering GRANT, a key mask is armed. req_keys[owner] is held at 0 until keys == 0 for one cycle, then the mask clears and req_keys[owner] = keys.
  - This prevents a press carried across the handoff from reaching the new owner.
- Only one gnt bit is ever set. gnt and the output mux source always agree in the same cycle.
- Reset mid-GRANT or mid-BLANK returns to IDLE asynchronously with all outputs 0.

Optional Feature:
- Macro TM_ARB_OWNER_LEDS_EN.
- Defined: in GRANT, ledr[n_req-1:0] is replaced with the one-hot owner indicator. ledr[w_led-1:n_req] comes from the owner's req_led.
- Undefined: ledr is the owner's req_led unmodified.
- Blanking behaviour is identical in both cases.

Decomposition:
- Package tm_arb_pkg holds:
  - state enum (IDLE, GRANT, BLANK);
  - functions slice_cycles(clk_mhz, slice_ms) and blank_cycles(clk_mhz, blank_us);
  - counter-width localparam helper.
- One natural sub-module: tm_rr_pick, combinational. Inputs req and ptr; outputs valid and index (first set bit at or after ptr, wrapped).

Test Plan (clk_mhz=1, slice_ms=1 → SLICE=1000, blank_us=10 → BLANK=10, n_req=4):
- req=0001 from idle → gnt=0001 next cycle; hgfedcba equals req_hgfedcba[7:0] one cycle after input change.
- Owner 0 holding, req=0011 → gnt=0001 for 1000 cycles; then 10 blank cycles with all outputs 0; then gnt=0010, owner=1.
- Owner 1 drops req at cycle 50 with req[3]=1 → BLANK immediately; after 10 cycles gnt=1000, owner=3.
- Handoff while keys=0x04 held → req_keys for the new owner stays 0 until keys=0; the next press 0x01 appears only in the owner's slice.
- req=0001 alone for 5000 cycles → gnt stays 0001, no blanking.
- Assert rst_n=0 mid-BLANK → all outputs 0 asynchronously. After release with req=0100 → gnt=0100.
